// File: rtl/clock_meter_pkg.sv
// Shared constants and FSM encoding for the clock period meter.
package clock_meter_pkg;

  localparam int unsigned DefaultCounterSize = 16;
  localparam int unsigned DefaultSyncStages  = 2;

  typedef enum logic [0:0] {
    StIdle    = 1'b0,
    StMeasure = 1'b1
  } meter_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer followed by an edge-detect flop. Edges are masked until the
// pipeline has refilled after reset, so a level already high at release is not a rise.
module sync_edge_detect
  import clock_meter_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = DefaultSyncStages
) (
  input  logic clk_in,
  input  logic reset,
  input  logic sig_in,
  output logic sync_level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  // Shadow chain of ones marking when sync_q and prev_q hold real samples.
  logic [SYNC_STAGES:0]   primed_q;

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= 1'b0;
      primed_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q   <= sync_q[SYNC_STAGES-1];
      primed_q <= {primed_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    sync_level = sync_q[SYNC_STAGES-1];
    rise       = primed_q[SYNC_STAGES] & sync_level & ~prev_q;
    fall       = primed_q[SYNC_STAGES] & ~sync_level & prev_q;
  end

endmodule

// File: rtl/clock_period_meter.sv
// Measures rise-to-rise period and high time of an asynchronous divided clock in
// clk_in cycles, with a sticky overflow flag when a period exceeds the counter range.
module clock_period_meter
  import clock_meter_pkg::*;
#(
  parameter int unsigned COUNTER_SIZE = DefaultCounterSize,
  parameter int unsigned SYNC_STAGES  = DefaultSyncStages
) (
  input  logic                    clk_in,
  input  logic                    reset,
  input  logic                    sig_in,
  output logic [COUNTER_SIZE-1:0] period,
  output logic [COUNTER_SIZE-1:0] high_time,
  output logic                    period_valid,
  output logic                    overflow
);

  localparam logic [COUNTER_SIZE-1:0] CntMax = '1;
  localparam logic [COUNTER_SIZE-1:0] CntOne = COUNTER_SIZE'(1);

  logic sync_level;
  logic rise;
  logic unused_fall;

  meter_state_e            state_q, state_d;
  logic [COUNTER_SIZE-1:0] period_cnt_q, period_cnt_d;
  logic [COUNTER_SIZE-1:0] high_cnt_q, high_cnt_d;
  logic [COUNTER_SIZE-1:0] period_q, period_d;
  logic [COUNTER_SIZE-1:0] high_q, high_d;
  logic                    valid_q, valid_d;
  logic                    overflow_q, overflow_d;

  sync_edge_detect #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge_detect (
    .clk_in     (clk_in),
    .reset      (reset),
    .sig_in     (sig_in),
    .sync_level (sync_level),
    .rise       (rise),
    .fall       (unused_fall)
  );

  always_comb begin
    state_d      = state_q;
    period_cnt_d = period_cnt_q;
    high_cnt_d   = high_cnt_q;
    period_d     = period_q;
    high_d       = high_q;
    valid_d      = 1'b0;
    overflow_d   = overflow_q;

    unique case (state_q)
      StIdle: begin
        if (rise) begin
          state_d      = StMeasure;
          period_cnt_d = CntOne;
          high_cnt_d   = CntOne;
        end
      end
      StMeasure: begin
        // A rise wins over overflow, so a period of exactly CntMax is still reported.
        if (rise) begin
          period_d     = period_cnt_q;
          high_d       = high_cnt_q;
          valid_d      = 1'b1;
          overflow_d   = 1'b0;
          period_cnt_d = CntOne;
          high_cnt_d   = CntOne;
        end else if (period_cnt_q == CntMax) begin
          overflow_d   = 1'b1;
          state_d      = StIdle;
          period_cnt_d = '0;
          high_cnt_d   = '0;
        end else begin
          period_cnt_d = period_cnt_q + CntOne;
          if (sync_level && (high_cnt_q != CntMax)) begin
            high_cnt_d = high_cnt_q + CntOne;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      period_cnt_q <= '0;
      high_cnt_q   <= '0;
      period_q     <= '0;
      high_q       <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      period_cnt_q <= period_cnt_d;
      high_cnt_q   <= high_cnt_d;
      period_q     <= period_d;
      high_q       <= high_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
    end
  end

  assign period       = period_q;
  assign high_time    = high_q;
  assign period_valid = valid_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench: a 16-bit meter for divider, reset and random-period cases, and an
// 8-bit meter for overflow and all-ones boundary cases, both against a segment-level model.
module tb_clock_period_meter;

  logic        clk = 1'b0;
  logic        rst16 = 1'b1;
  logic        rst8 = 1'b1;
  logic        sig16 = 1'b0;
  logic        sig8 = 1'b0;
  logic [15:0] p16, h16;
  logic [7:0]  p8, h8;
  logic        v16, o16, v8, o8;

  int checks = 0;
  int fails = 0;

  // Model: a waveform is a list of segments (period P, high H) each starting with a rise.
  // The rise opening a segment reports the previous one if the meter was armed and the
  // previous period fit the counter; otherwise that rise only re-arms.
  int exp_p16[$];
  int exp_h16[$];
  int exp_p8[$];
  int exp_h8[$];
  bit armed16 = 0;
  bit armed8 = 0;
  int last_p16, last_h16, last_p8, last_h8;

  always #5 clk = ~clk;

  clock_period_meter u_dut16 (
    .clk_in       (clk),
    .reset        (rst16),
    .sig_in       (sig16),
    .period       (p16),
    .high_time    (h16),
    .period_valid (v16),
    .overflow     (o16)
  );

  clock_period_meter #(
    .COUNTER_SIZE (8),
    .SYNC_STAGES  (2)
  ) u_dut8 (
    .clk_in       (clk),
    .reset        (rst8),
    .sig_in       (sig8),
    .period       (p8),
    .high_time    (h8),
    .period_valid (v8),
    .overflow     (o8)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rise16(input int p, input int h);
    if (armed16 && last_p16 <= 65535) begin
      exp_p16.push_back(last_p16);
      exp_h16.push_back(last_h16);
    end
    armed16 = 1;
    last_p16 = p;
    last_h16 = h;
  endtask

  task automatic seg16(input int p, input int h);
    rise16(p, h);
    for (int i = 0; i < p; i++) begin
      sig16 = (i < h);
      tick();
    end
  endtask

  task automatic idle16(input int n);
    sig16 = 1'b0;
    for (int i = 0; i < n; i++) tick();
    last_p16 += n;
  endtask

  task automatic seg8(input int p, input int h);
    if (armed8 && last_p8 <= 255) begin
      exp_p8.push_back(last_p8);
      exp_h8.push_back(last_h8);
    end
    armed8 = 1;
    last_p8 = p;
    last_h8 = h;
    for (int i = 0; i < p; i++) begin
      sig8 = (i < h);
      tick();
    end
  endtask

  always @(negedge clk) begin : mon16
    int ep, eh;
    if (v16 === 1'b1) begin
      check("pulse16_expected", exp_p16.size() > 0, 1);
      if (exp_p16.size() > 0) begin
        ep = exp_p16.pop_front();
        eh = exp_h16.pop_front();
        check("period16", p16, ep);
        check("high16", h16, eh);
      end
    end
  end

  always @(negedge clk) begin : mon8
    int ep, eh;
    if (v8 === 1'b1) begin
      check("pulse8_expected", exp_p8.size() > 0, 1);
      if (exp_p8.size() > 0) begin
        ep = exp_p8.pop_front();
        eh = exp_h8.pop_front();
        check("period8", p8, ep);
        check("high8", h8, eh);
      end
    end
  end

  initial begin
    int p, h;
    tick();
    tick();
    check("rst_period16", p16, 0);
    check("rst_high16", h16, 0);
    check("rst_valid16", v16, 0);
    check("rst_ovf16", o16, 0);
    check("rst_period8", p8, 0);
    check("rst_high8", h8, 0);
    check("rst_valid8", v8, 0);
    check("rst_ovf8", o8, 0);
    rst16 = 1'b0;
    rst8 = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    // Size-8 divider MSB: rises at 128, 384, 640, 896; the first only arms.
    for (int k = 0; k < 3; k++) begin
      exp_p16.push_back(256);
      exp_h16.push_back(128);
    end
    for (int i = 0; i < 1152; i++) begin
      sig16 = ((i % 256) >= 128);
      tick();
    end
    armed16 = 1;
    last_p16 = 256;
    last_h16 = 128;
    idle16(10);
    check("pending16_div", exp_p16.size(), 0);

    // Held outputs then reset mid-period.
    seg16(20, 10);
    seg16(20, 10);
    seg16(20, 10);
    rise16(20, 10);
    for (int i = 0; i < 8; i++) begin
      sig16 = 1'b1;
      tick();
    end
    check("held_period16", p16, 20);
    rst16 = 1'b1;
    sig16 = 1'b0;
    #1;
    check("midrst_period16", p16, 0);
    check("midrst_high16", h16, 0);
    check("midrst_valid16", v16, 0);
    check("midrst_ovf16", o16, 0);
    tick();
    rst16 = 1'b0;
    armed16 = 0;
    for (int i = 0; i < 5; i++) tick();
    seg16(14, 7);
    seg16(14, 7);
    seg16(14, 7);

    // Minimum period of two cycles.
    for (int i = 0; i < 10; i++) seg16(2, 1);
    idle16(10);
    check("pending16_min", exp_p16.size(), 0);

    // Input already high when reset releases.
    sig16 = 1'b1;
    rst16 = 1'b1;
    tick();
    tick();
    rst16 = 1'b0;
    armed16 = 0;
    for (int i = 0; i < 10; i++) tick();
    sig16 = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    seg16(12, 4);
    seg16(12, 4);

    for (int i = 0; i < 30; i++) begin
      p = int'($urandom_range(500, 3));
      h = int'($urandom_range(p - 1, 1));
      seg16(p, h);
    end
    idle16(10);
    check("pending16_rand", exp_p16.size(), 0);
    check("ovf16_never", o16, 0);

    // 8-bit meter: overflow after one rise, then recovery with a 10-cycle clock.
    seg8(300, 5);
    check("ovf8_set", o8, 1);
    check("ovf8_no_pulse", exp_p8.size(), 0);
    seg8(10, 5);
    check("ovf8_sticky_rearm", o8, 1);
    seg8(10, 5);
    check("ovf8_cleared", o8, 0);
    // Period of exactly all-ones is reported; one more cycle overflows.
    seg8(255, 100);
    seg8(256, 100);
    seg8(10, 5);
    check("ovf8_at_256", o8, 1);
    seg8(10, 5);
    check("ovf8_cleared2", o8, 0);
    sig8 = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("pending8", exp_p8.size(), 0);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/clock_period_meter.md
CLOCK_PERIOD_METER -- requirements
Module: clock_period_meter

Interface
REQ-001 Parameter COUNTER_SIZE, default 16: width of the period and high-time counters and outputs.
REQ-002 Parameter SYNC_STAGES, default 2, minimum 2: number of synchronizer flops on sig_in.
REQ-003 clk_in  input  1  measurement clock; one clock domain, all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 sig_in  input  1  divided-clock signal under measurement, asynchronous to clk_in.
REQ-006 period  output  COUNTER_SIZE  clk_in cycles between two consecutive sig_in rising edges.
REQ-007 high_time  output  COUNTER_SIZE  clk_in cycles sig_in was high within that period.
REQ-008 period_valid  output  1  one-cycle pulse; period and high_time hold a new measurement.
REQ-009 overflow  output  1  sticky flag; a period exceeded the counter range.

Function
REQ-010 sig_in SHALL pass through SYNC_STAGES flops, then one edge-detect flop; a rise or fall is detected SYNC_STAGES+1 clk_in cycles after sig_in changes.
REQ-011 FSM states: IDLE (await first rise), MEASURE (counting); encoding 1 bit.
REQ-012 IDLE: on a detected rise -> MEASURE, period counter loads 1, high counter loads 1; no period_valid.
REQ-013 MEASURE: each cycle without a rise, period counter +1; high counter +1 while synchronized sig_in is 1.
REQ-014 MEASURE, detected rise: period <= period counter, high_time <= high counter, period_valid = 1 for that one cycle (registered), overflow <= 0, both counters reload 1, remain in MEASURE.
REQ-015 period and high_time SHALL hold their last values between pulses.
REQ-016 Period counter reaching all-ones (2**COUNTER_SIZE - 1) without a rise: overflow <= 1, no period_valid, -> IDLE; the counter SHALL never wrap.
REQ-017 Rise coinciding with counter at all-ones: treat as a rise (REQ-014), not overflow.
REQ-018 High counter SHALL saturate at all-ones and never exceed period.
REQ-019 Minimum measurable period is 2 clk_in cycles; shorter input behaviour is undefined.
REQ-020 A driving divider of size N (output = counter MSB) SHALL measure period 2**N, high_time 2**(N-1).

Reset
REQ-021 reset SHALL asynchronously force: FSM IDLE, synchronizer and edge flops 0, counters 0, period 0, high_time 0, period_valid 0, overflow 0.
REQ-022 Reset asserted mid-measurement SHALL discard the partial count; after release the first rise only re-arms (REQ-012).
REQ-023 sig_in high at reset release SHALL NOT count as a rise.

Structure
REQ-024 Shared package clock_meter_pkg SHALL hold the FSM state encodings and the default COUNTER_SIZE/SYNC_STAGES constants.
REQ-025 One sub-module sync_edge_detect (parameter SYNC_STAGES; outputs sync level, rise, fall) SHALL be instantiated; counters and FSM stay in clock_period_meter.
REQ-026 No combinational path from sig_in to any output.

Verification
REQ-027 Drive sig_in from a size-8 divider on clk_in -> first rise gives no pulse; each later rise gives period_valid with period=256, high_time=128.
REQ-028 sig_in held 0 after one rise, COUNTER_SIZE=8 -> overflow=1 once the counter reaches 255, no period_valid; then a 10-cycle period clock -> period=10, overflow cleared on the second rise after recovery.
REQ-029 Reset pulsed mid-period -> all outputs 0 immediately; first post-reset rise gives no pulse; next gives the correct period.
REQ-030 sig_in period 2, duty 1/2 -> every rise after the first gives period=2, high_time=1.
REQ-031 sig_in high at reset release -> no rise detected until sig_in goes low and high again.
REQ-032 Random sig_in period 3..500, COUNTER_SIZE=16 -> every pulse matches a model counting synchronized rise-to-rise.
